// File: rtl/dqsw_train_ctrl_if.sv
// Signal bundle between the DQS write-training controller and the fabric/IOD side.
// The controller connects through the slave modport; the fabric/IOD side uses master.
interface dqsw_train_ctrl_if;
    logic       train_start;
    logic       eye_monitor_early;
    logic       eye_monitor_late;
    logic       delay_line_out_of_range;
    logic       delay_line_load;
    logic       delay_line_move;
    logic       delay_line_direction;
    logic       eye_monitor_clear_flags;
    logic       train_busy;
    logic       train_done;
    logic       train_err;
    logic [7:0] tap_count;

    modport master (
        output train_start, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        input  delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
        input  train_busy, train_done, train_err, tap_count
    );

    modport slave (
        input  train_start, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        output delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
        output train_busy, train_done, train_err, tap_count
    );
endinterface

// File: rtl/dqsw_train_ctrl.sv
// DQS write-training controller: steps the IOD delay one tap at a time until the eye monitor reports early.
// Optional build macro DQSW_TRAIN_LATE_CHK_EN: a tap showing both early and late flags fails as ambiguous.
module dqsw_train_ctrl #(
    parameter int STEP_MAX      = 127,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic             fab_clk,
    input  logic             reset,
    dqsw_train_ctrl_if.slave bus
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LOAD   = 4'd1;
    localparam logic [3:0] ST_CLEAR  = 4'd2;
    localparam logic [3:0] ST_SETTLE = 4'd3;
    localparam logic [3:0] ST_SAMPLE = 4'd4;
    localparam logic [3:0] ST_EVAL   = 4'd5;
    localparam logic [3:0] ST_MOVE   = 4'd6;
    localparam logic [3:0] ST_DONE   = 4'd7;
    localparam logic [3:0] ST_ERR    = 4'd8;

    localparam logic [7:0] STEP_MAX_C    = 8'(STEP_MAX);
    localparam logic [7:0] SETTLE_LOAD_C = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LOAD_C = 8'(SAMPLE_CYCLES - 1);

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic [7:0] tap_r;
    logic [7:0] tap_next_s;
    logic       early_seen_r;
    logic       early_seen_next_s;
    logic       ambiguous_s;
    logic       in_search_s;

    logic       load_r;
    logic       move_r;
    logic       dir_r;
    logic       clear_r;
    logic       busy_r;
    logic       done_r;
    logic       err_r;

`ifdef DQSW_TRAIN_LATE_CHK_EN
    logic       late_seen_r;
    logic       late_seen_next_s;

    // Late-flag accumulator, same window as the early one
    always_comb begin
        late_seen_next_s = late_seen_r;
        if (state_r == ST_CLEAR) begin
            late_seen_next_s = 1'b0;
        end else if (state_r == ST_SAMPLE) begin
            late_seen_next_s = late_seen_r | bus.eye_monitor_late;
        end else begin
            late_seen_next_s = late_seen_r;
        end
    end

    // Late-flag accumulator register
    always_ff @(posedge fab_clk or posedge reset) begin
        if (reset) begin
            late_seen_r <= 1'b0;
        end else begin
            late_seen_r <= late_seen_next_s;
        end
    end

    assign ambiguous_s = early_seen_r & late_seen_r;
`else
    logic unused_late_s;
    assign unused_late_s = bus.eye_monitor_late;
    assign ambiguous_s   = 1'b0;
`endif

    // Out-of-range aborts every busy state except the single LOAD cycle
    assign in_search_s = (state_r == ST_CLEAR) || (state_r == ST_SETTLE) || (state_r == ST_SAMPLE) ||
                         (state_r == ST_EVAL)  || (state_r == ST_MOVE);

    // Next-state and window counter
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.train_start) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LOAD: begin
                next_state_s = ST_CLEAR;
            end
            ST_CLEAR: begin
                next_state_s = ST_SETTLE;
                cnt_next_s   = SETTLE_LOAD_C;
            end
            ST_SETTLE: begin
                if (cnt_r == 8'd0) begin
                    next_state_s = ST_SAMPLE;
                    cnt_next_s   = SAMPLE_LOAD_C;
                end else begin
                    cnt_next_s   = cnt_r - 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (cnt_r == 8'd0) begin
                    next_state_s = ST_EVAL;
                end else begin
                    cnt_next_s   = cnt_r - 8'd1;
                end
            end
            ST_EVAL: begin
                if (ambiguous_s) begin
                    next_state_s = ST_ERR;
                end else if (early_seen_r) begin
                    next_state_s = ST_DONE;
                end else if (tap_r == STEP_MAX_C) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_MOVE;
                end
            end
            ST_MOVE: begin
                next_state_s = ST_CLEAR;
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase
        if (in_search_s && bus.delay_line_out_of_range) begin
            next_state_s = ST_ERR;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Tap offset and early-flag accumulator; the tap advances on entry to MOVE so it never passes STEP_MAX
    always_comb begin
        tap_next_s        = tap_r;
        early_seen_next_s = early_seen_r;
        if (next_state_s == ST_LOAD) begin
            tap_next_s = 8'd0;
        end else if ((next_state_s == ST_MOVE) && (state_r != ST_MOVE)) begin
            tap_next_s = tap_r + 8'd1;
        end else begin
            tap_next_s = tap_r;
        end
        if (state_r == ST_CLEAR) begin
            early_seen_next_s = 1'b0;
        end else if (state_r == ST_SAMPLE) begin
            early_seen_next_s = early_seen_r | bus.eye_monitor_early;
        end else begin
            early_seen_next_s = early_seen_r;
        end
    end

    // State, counters and outputs; outputs are decoded from the next state so they line up with it
    always_ff @(posedge fab_clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            tap_r        <= 8'd0;
            early_seen_r <= 1'b0;
            load_r       <= 1'b0;
            move_r       <= 1'b0;
            dir_r        <= 1'b0;
            clear_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cnt_r        <= cnt_next_s;
            tap_r        <= tap_next_s;
            early_seen_r <= early_seen_next_s;
            load_r       <= (next_state_s == ST_LOAD);
            move_r       <= (next_state_s == ST_MOVE);
            dir_r        <= (next_state_s != ST_IDLE);
            clear_r      <= (next_state_s == ST_CLEAR);
            busy_r       <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE) &&
                            (next_state_s != ST_ERR);
            done_r       <= (next_state_s == ST_DONE);
            err_r        <= (next_state_s == ST_ERR);
        end
    end

    assign bus.delay_line_load         = load_r;
    assign bus.delay_line_move         = move_r;
    assign bus.delay_line_direction    = dir_r;
    assign bus.eye_monitor_clear_flags = clear_r;
    assign bus.train_busy              = busy_r;
    assign bus.train_done              = done_r;
    assign bus.train_err               = err_r;
    assign bus.tap_count               = tap_r;

endmodule
